// File: rtl/call_stack_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : call_stack_unit_if
//  Brief    : Controller <-> return-address stack request/response bundle.
//             Optional stack_underflow present with CALL_STACK_UNDERFLOW_EN.
//  Revision : 1.0  initial release
// ============================================================================
interface call_stack_unit_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             stack_push;
    logic             stack_pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top_data;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             stack_overflow;
`ifdef CALL_STACK_UNDERFLOW_EN
    logic             stack_underflow;
`endif

    modport master (
        output flush, stack_push, stack_pop, push_data,
        input  top_data, empty, full, count, stack_overflow
`ifdef CALL_STACK_UNDERFLOW_EN
        , input stack_underflow
`endif
    );

    modport slave (
        input  flush, stack_push, stack_pop, push_data,
        output top_data, empty, full, count, stack_overflow
`ifdef CALL_STACK_UNDERFLOW_EN
        , output stack_underflow
`endif
    );
endinterface
`default_nettype wire

// File: rtl/call_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : call_stack_unit
//  Brief    : LIFO return-address stack with sticky overflow flag.
//             Macro CALL_STACK_UNDERFLOW_EN adds a sticky stack_underflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module call_stack_unit #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    call_stack_unit_if.slave  bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic             w_empty;
    logic             w_full;
`ifdef CALL_STACK_UNDERFLOW_EN
    logic             r_underflow;
    logic             w_underflow_nxt;
`endif

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH);
    assign w_top_idx = AW'(r_count - 1'b1);

    always_comb begin
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_wr_en        = 1'b0;
        w_wr_idx       = AW'(r_count);
`ifdef CALL_STACK_UNDERFLOW_EN
        w_underflow_nxt = r_underflow;
`endif
        if (bus.flush) begin
            w_count_nxt = '0;
        end else if (bus.stack_push && bus.stack_pop && !w_empty) begin
            // Replace the top in place; legal even when full, never flags.
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (bus.stack_push) begin
            if (w_full) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_wr_en     = 1'b1;
                w_count_nxt = r_count + 1'b1;
            end
        end else if (bus.stack_pop) begin
            if (!w_empty) begin
                w_count_nxt = r_count - 1'b1;
            end
`ifdef CALL_STACK_UNDERFLOW_EN
            else begin
                w_underflow_nxt = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

`ifdef CALL_STACK_UNDERFLOW_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_underflow_nxt;
        end
    end

    assign bus.stack_underflow = r_underflow;
`endif

    // Storage is never reset: the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_data;
        end
    end

    assign bus.top_data       = w_empty ? '0 : r_mem[w_top_idx];
    assign bus.empty          = w_empty;
    assign bus.full           = w_full;
    assign bus.count          = r_count;
    assign bus.stack_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_call_stack_unit
//  Brief    : Self-checking bench for call_stack_unit against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_call_stack_unit;
    localparam int DEPTH = 4;
    localparam int WIDTH = 12;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef CALL_STACK_UNDERFLOW_EN
    localparam int VW    = CW + WIDTH + 4;
`else
    localparam int VW    = CW + WIDTH + 3;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    call_stack_unit_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) sif ();

    call_stack_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue back is the top of stack.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;

    logic [VW-1:0] obs;
`ifdef CALL_STACK_UNDERFLOW_EN
    assign obs = {sif.count, sif.top_data, sif.empty, sif.full, sif.stack_overflow, sif.stack_underflow};
`else
    assign obs = {sif.count, sif.top_data, sif.empty, sif.full, sif.stack_overflow};
`endif

    function automatic logic [VW-1:0] exp_vec();
        logic [CW-1:0]    c;
        logic [WIDTH-1:0] t;
        c = CW'(q.size());
        t = (q.size() > 0) ? q[$] : '0;
`ifdef CALL_STACK_UNDERFLOW_EN
        return {c, t, q.size() == 0, q.size() == DEPTH, m_ovf, m_unf};
`else
        return {c, t, q.size() == 0, q.size() == DEPTH, m_ovf};
`endif
    endfunction

    function automatic void model_apply(bit pu, bit po, bit fl, logic [WIDTH-1:0] d);
        if (fl) begin
            q.delete();
        end else if (pu && po && q.size() > 0) begin
            q[q.size()-1] = d;
        end else if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovf = 1'b1;
        end else if (po) begin
            if (q.size() > 0) void'(q.pop_back());
            else              m_unf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Apply one request across a rising edge; returns #1 after that edge.
    task automatic step(input bit pu, input bit po, input bit fl, input logic [WIDTH-1:0] d);
        sif.stack_push = pu;
        sif.stack_pop  = po;
        sif.flush      = fl;
        sif.push_data  = d;
        @(posedge clk);
        model_apply(pu, po, fl, d);
        #1;
        sif.stack_push = 1'b0;
        sif.stack_pop  = 1'b0;
        sif.flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sif.flush = 1'b0; sif.stack_push = 1'b0; sif.stack_pop = 1'b0; sif.push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_push_pop();
        step(1, 0, 0, 12'h010);
        step(1, 0, 0, 12'h020);
        step(1, 0, 0, 12'h030);
        n_tests++;
        if (sif.top_data !== 12'h030 || sif.count !== 3'd3) begin
            n_fail++;
            $display("FAIL push3_top: got top %h count %0d expected top 030 count 3", sif.top_data, sif.count);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, '0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL pop_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_tests++;
        if (sif.top_data !== 12'h000 || sif.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pop_to_empty: got top %h empty %b expected top 000 empty 1", sif.top_data, sif.empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 12'(i));
        n_tests++;
        if (sif.full !== 1'b1 || sif.stack_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got full %b ovf %b expected full 1 ovf 0", sif.full, sif.stack_overflow);
        end
        step(1, 0, 0, 12'h005);
        n_tests++;
        if (sif.count !== 3'd4 || sif.top_data !== 12'h004 || sif.stack_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL push_full: got count %0d top %h ovf %b expected count 4 top 004 ovf 1",
                     sif.count, sif.top_data, sif.stack_overflow);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        n_tests++;
        if (obs !== exp_vec() || sif.stack_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %h expected %h", obs, exp_vec());
        end
        step(0, 1, 0, '0);
    endtask

    task automatic test_replace();
        step(1, 0, 0, 12'h055);
        step(1, 0, 0, 12'h0AA);
        step(1, 1, 0, 12'h0BB);
        n_tests++;
        if (sif.count !== 3'd2 || sif.top_data !== 12'h0BB) begin
            n_fail++;
            $display("FAIL replace_top: got count %0d top %h expected count 2 top 0bb", sif.count, sif.top_data);
        end
        step(0, 1, 0, '0);
        n_tests++;
        if (sif.top_data !== 12'h055) begin
            n_fail++;
            $display("FAIL replace_older: got top %h expected 055", sif.top_data);
        end
        step(0, 1, 0, '0);
        step(1, 1, 0, 12'h0CC);
        n_tests++;
        if (obs !== exp_vec() || sif.count !== 3'd1 || sif.top_data !== 12'h0CC) begin
            n_fail++;
            $display("FAIL replace_empty: got %h expected %h", obs, exp_vec());
        end
        // Replace while full must not raise overflow beyond what the model says.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 12'(12'h100 + i));
        step(1, 1, 0, 12'h1FF);
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL replace_full: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_flush();
        step(0, 1, 0, '0);
        n_tests++;
        if (sif.count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre: got count %0d expected 3", sif.count);
        end
        step(1, 0, 1, 12'h777);
        n_tests++;
        if (obs !== exp_vec() || sif.count !== 3'd0 || sif.empty !== 1'b1 || sif.top_data !== 12'h000) begin
            n_fail++;
            $display("FAIL flush: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 12'(12'h200 + i));
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        n_tests++;
        if (sif.count !== 3'd2 || sif.stack_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got count %0d ovf %b expected count 2 ovf 1", sif.count, sif.stack_overflow);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_vec());
        end
        #2;
        rst = 1'b1;
        step(1, 0, 0, 12'h3C3);
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL arst_release: got %h expected %h", obs, exp_vec());
        end
        step(0, 1, 0, '0);
    endtask

    task automatic test_pop_empty();
        step(0, 1, 0, '0);
        n_tests++;
        if (obs !== exp_vec() || sif.count !== 3'd0) begin
            n_fail++;
            $display("FAIL pop_empty: got %h expected %h", obs, exp_vec());
        end
        step(1, 0, 0, 12'h0F0);
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL pop_empty_sticky: got %h expected %h", obs, exp_vec());
        end
        step(0, 1, 0, '0);
    endtask

    task automatic test_random();
        bit               pu, po, fl;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 15) == 0);
            pu = $urandom_range(0, 1) == 1;
            po = $urandom_range(0, 2) == 0;
            d  = WIDTH'($urandom_range(0, 4095));
            step(pu, po, fl, d);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h expected %h (push %b pop %b flush %b)",
                         i, obs, exp_vec(), pu, po, fl);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_replace();
        test_flush();
        test_async_reset();
        test_pop_empty();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
